// File: rtl/mem_wb_stage_lanes_if.sv
// Data-memory request/ack bus between the MEM stage (master) and a variable-latency memory (slave).
interface mem_wb_stage_lanes_if #(
    parameter int LEN_DATA = 32,
    parameter int ADDR_W   = 10
);
    localparam int NUM_LANES = LEN_DATA / 8;
    localparam int OFF_W     = $clog2(NUM_LANES);

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-OFF_W-1:0] mem_addr;
    logic [NUM_LANES-1:0]    mem_be;
    logic [LEN_DATA-1:0]     mem_wdata;
    logic                    mem_ack;
    logic [LEN_DATA-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage_lanes.sv
// MEM stage plus MEM/WB register: byte-lane stores/loads over a req/ack memory bus,
// stall generation, bus timeout, misalign and bus-error flags, combinational branch resolve.
module mem_wb_stage_lanes #(
    parameter int LEN_DATA    = 32,
    parameter int ADDR_W      = 10,
    parameter int NUM_BITS    = 5,
    parameter int LEN_MEM_BUS = 9,
    parameter int LEN_WB_BUS  = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_wb_stage_lanes_if.master   mem,
    input  logic                   valid_in,
    input  logic [LEN_DATA-1:0]    in_addr_mem,
    input  logic [LEN_DATA-1:0]    write_data,
    input  logic [LEN_MEM_BUS-1:0] memory_bus,
    input  logic [LEN_WB_BUS-1:0]  in_writeBack_bus,
    input  logic [NUM_BITS-1:0]    in_write_reg,
    input  logic                   zero_flag,
    input  logic [LEN_DATA-1:0]    in_pc_branch,
    input  logic                   halt_flag_m,
    output logic                   stall,
    output logic                   pc_src,
    output logic [LEN_DATA-1:0]    out_pc_branch,
    output logic [LEN_DATA-1:0]    read_data,
    output logic [LEN_WB_BUS-1:0]  out_writeBack_bus,
    output logic [LEN_DATA-1:0]    out_addr_mem,
    output logic [NUM_BITS-1:0]    out_write_reg,
    output logic                   out_halt_flag_m,
    output logic                   out_valid,
    output logic                   out_misalign,
    output logic                   out_bus_err
);
    localparam int NUM_LANES = LEN_DATA / 8;
    localparam int OFF_W     = $clog2(NUM_LANES);
    localparam int CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // control bus decode
    logic ctl_write, ctl_read, ctl_branch, ctl_unsigned, ctl_bne;
    logic is_byte, is_half, misalign, mem_op;
    logic [OFF_W-1:0] off;

    assign ctl_write    = memory_bus[0];
    assign ctl_read     = memory_bus[1];
    assign ctl_branch   = memory_bus[2];
    assign ctl_unsigned = memory_bus[3];
    assign ctl_bne      = memory_bus[8];
    assign is_byte      = memory_bus[5] | memory_bus[7];
    assign is_half      = memory_bus[4] | memory_bus[6];
    assign off          = in_addr_mem[OFF_W-1:0];
    assign misalign     = is_byte ? 1'b0 : (is_half ? off[0] : (off != '0));
    assign mem_op       = valid_in & (ctl_read | ctl_write);

    assign pc_src        = ctl_branch & (ctl_bne ? ~zero_flag : zero_flag) & valid_in;
    assign out_pc_branch = in_pc_branch;

    // store lane steering: replicate the narrow datum into every lane, enable only the addressed lane(s)
    logic [LEN_DATA-1:0]  st_wdata;
    logic [NUM_LANES-1:0] st_be;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign st_wdata[gi*8 +: 8] = is_byte ? write_data[7:0] :
                                         is_half ? write_data[(gi%2)*8 +: 8] :
                                                   write_data[gi*8 +: 8];
            assign st_be[gi] = is_byte ? (off == OFF_W'(gi)) :
                               is_half ? ((off >> 1) == OFF_W'(gi / 2)) :
                                         1'b1;
        end
    endgenerate

    // load formatting; word accesses are only issued with off == 0, so the shift is a no-op for them
    logic [LEN_DATA-1:0] rd_shift;
    logic [LEN_DATA-1:0] ld_fmt;

    assign rd_shift = mem.mem_rdata >> {off, 3'b000};

    // select the addressed lane(s) and zero/sign extend
    always_comb begin
        ld_fmt = rd_shift;
        if (is_byte) begin
            ld_fmt = {{(LEN_DATA-8){~ctl_unsigned & rd_shift[7]}}, rd_shift[7:0]};
        end else if (is_half) begin
            ld_fmt = {{(LEN_DATA-16){~ctl_unsigned & rd_shift[15]}}, rd_shift[15:0]};
        end
    end

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    mem_req_reg, mem_we_reg;
    logic [ADDR_W-OFF_W-1:0] mem_addr_reg;
    logic [NUM_LANES-1:0]    mem_be_reg;
    logic [LEN_DATA-1:0]     mem_wdata_reg;

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_be    = mem_be_reg;
    assign mem.mem_wdata = mem_wdata_reg;

    // hold upstream while a request is being launched or is outstanding; release on ack or timeout
    always_comb begin
        stall = 1'b0;
        if (state_reg == IDLE) begin
            stall = mem_op & ~misalign;
        end else begin
            stall = ~mem.mem_ack & (cnt_reg != CNT_LAST);
        end
    end

    // bus FSM and MEM/WB output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            mem_req_reg       <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= '0;
            mem_be_reg        <= '0;
            mem_wdata_reg     <= '0;
            read_data         <= '0;
            out_writeBack_bus <= '0;
            out_addr_mem      <= '0;
            out_write_reg     <= '0;
            out_halt_flag_m   <= 1'b0;
            out_valid         <= 1'b0;
            out_misalign      <= 1'b0;
            out_bus_err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    out_addr_mem  <= in_addr_mem;
                    out_write_reg <= in_write_reg;
                    read_data     <= '0;
                    out_bus_err   <= 1'b0;
                    if (mem_op && !misalign) begin
                        state_reg         <= BUSY;
                        cnt_reg           <= '0;
                        mem_req_reg       <= 1'b1;
                        mem_we_reg        <= ctl_write;
                        mem_addr_reg      <= in_addr_mem[ADDR_W-1:OFF_W];
                        mem_be_reg        <= st_be;
                        mem_wdata_reg     <= st_wdata;
                        out_valid         <= 1'b0;
                        out_writeBack_bus <= '0;
                        out_halt_flag_m   <= 1'b0;
                        out_misalign      <= 1'b0;
                    end else if (mem_op) begin
                        out_valid         <= 1'b1;
                        out_writeBack_bus <= '0;
                        out_halt_flag_m   <= halt_flag_m;
                        out_misalign      <= 1'b1;
                    end else begin
                        out_valid         <= valid_in;
                        out_writeBack_bus <= in_writeBack_bus;
                        out_halt_flag_m   <= halt_flag_m;
                        out_misalign      <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (mem.mem_ack) begin
                        state_reg         <= IDLE;
                        mem_req_reg       <= 1'b0;
                        read_data         <= (ctl_read && !ctl_write) ? ld_fmt : '0;
                        out_valid         <= 1'b1;
                        out_writeBack_bus <= in_writeBack_bus;
                        out_addr_mem      <= in_addr_mem;
                        out_write_reg     <= in_write_reg;
                        out_halt_flag_m   <= halt_flag_m;
                        out_misalign      <= 1'b0;
                        out_bus_err       <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg         <= IDLE;
                        mem_req_reg       <= 1'b0;
                        read_data         <= '0;
                        out_valid         <= 1'b1;
                        out_writeBack_bus <= '0;
                        out_addr_mem      <= in_addr_mem;
                        out_write_reg     <= in_write_reg;
                        out_halt_flag_m   <= halt_flag_m;
                        out_misalign      <= 1'b0;
                        out_bus_err       <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
